// File: rtl/pc_target_btb_if.sv
// Fetch/execute bus of the next-PC generator: fetch PC and prediction toward
// instruction memory, resolved execute info in, redirect/flush toward the hazard unit.
interface pc_target_btb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  stall_f;
    logic [DATA_WIDTH-1:0] PCF;
    logic [DATA_WIDTH-1:0] PCPlus4F;
    logic                  pred_taken_f;
    logic [DATA_WIDTH-1:0] pred_target_f;
    logic                  ex_valid;
    logic [6:0]            ex_op;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [DATA_WIDTH-1:0] ex_alu_result;
    logic                  ex_branch_taken;
    logic                  ex_pred_taken;
    logic [DATA_WIDTH-1:0] ex_pred_target;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  mispredict_cnt;
    logic                  misalign;

    modport master (
        output stall_f, ex_valid, ex_op, ex_pc, ex_imm, ex_alu_result,
               ex_branch_taken, ex_pred_taken, ex_pred_target,
        input  PCF, PCPlus4F, pred_taken_f, pred_target_f,
               redirect, redirect_pc, mispredict_cnt, misalign
    );

    modport slave (
        input  stall_f, ex_valid, ex_op, ex_pc, ex_imm, ex_alu_result,
               ex_branch_taken, ex_pred_taken, ex_pred_target,
        output PCF, PCPlus4F, pred_taken_f, pred_target_f,
               redirect, redirect_pc, mispredict_cnt, misalign
    );
endinterface

// File: rtl/pc_target_btb.sv
// Fetch PC register with direct-mapped BTB prediction and execute-stage target resolution.
// Optional PCT_MISALIGN_CHK_EN: flag targets with bit 1 set and keep them out of the BTB.
module pc_target_btb #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    CNT_WIDTH   = 16
) (
    input logic            clk,
    input logic            rst,
    pc_target_btb_if.slave bus
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX - 2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [DATA_WIDTH-1:0]  btb_target [BTB_ENTRIES];

    logic [DATA_WIDTH-1:0] pcf;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pred_target;
    logic [IDX-1:0]        f_idx;
    logic [TAG_W-1:0]      f_tag;
    logic                  f_hit;
    logic [CNT_WIDTH-1:0]  cnt;

    logic [IDX-1:0]        ex_idx;
    logic [TAG_W-1:0]      ex_tag;
    logic                  act_taken;
    logic [DATA_WIDTH-1:0] act_target;
    logic                  mismatch;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  bad_tgt;
    logic                  btb_wr;
    logic                  btb_inv;

    // Fetch: combinational BTB lookup on the current PC
    assign f_idx       = pcf[IDX+1:2];
    assign f_tag       = pcf[DATA_WIDTH-1:IDX+2];
    assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign pc_plus4    = pcf + DATA_WIDTH'(4);
    assign pred_target = f_hit ? btb_target[f_idx] : pc_plus4;

    assign bus.PCF            = pcf;
    assign bus.PCPlus4F       = pc_plus4;
    assign bus.pred_taken_f   = f_hit;
    assign bus.pred_target_f  = pred_target;
    assign bus.mispredict_cnt = cnt;

    // Execute: resolve actual direction/target and compare with the carried prediction
    assign ex_idx = bus.ex_pc[IDX+1:2];
    assign ex_tag = bus.ex_pc[DATA_WIDTH-1:IDX+2];

    always_comb begin
        act_taken  = 1'b0;
        act_target = bus.ex_pc + bus.ex_imm;
        case (bus.ex_op)
            OP_JAL:    act_taken = 1'b1;
            OP_JALR: begin
                act_taken  = 1'b1;
                act_target = {bus.ex_alu_result[DATA_WIDTH-1:1], 1'b0};
            end
            OP_BRANCH: act_taken = bus.ex_branch_taken;
            default:   act_taken = 1'b0;
        endcase
    end

    assign mismatch    = (act_taken != bus.ex_pred_taken) ||
                         (act_taken && (bus.ex_pred_target != act_target));
    assign redirect    = bus.ex_valid && !rst && mismatch;
    assign redirect_pc = act_taken ? act_target : bus.ex_pc + DATA_WIDTH'(4);

`ifdef PCT_MISALIGN_CHK_EN
    assign bad_tgt      = act_target[1];
    assign bus.misalign = redirect && act_taken && act_target[1];
`else
    assign bad_tgt      = 1'b0;
    assign bus.misalign = 1'b0;
`endif

    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;

    // A not-taken instruction that was predicted taken clears whatever entry aliased it
    assign btb_wr  = bus.ex_valid && act_taken && !bad_tgt;
    assign btb_inv = bus.ex_valid && !act_taken && bus.ex_pred_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcf       <= RESET_PC;
            btb_valid <= '0;
            cnt       <= '0;
        end else begin
            if (redirect) begin
                pcf <= redirect_pc;
            end else if (!bus.stall_f) begin
                pcf <= pred_target;
            end
            if (btb_wr) begin
                btb_valid[ex_idx] <= 1'b1;
            end else if (btb_inv) begin
                btb_valid[ex_idx] <= 1'b0;
            end
            if (redirect) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= act_target;
        end
    end
endmodule

// File: tb/tb_pc_target_btb.sv
// Scoreboard bench for pc_target_btb: each cycle queues expected outputs with its
// stimulus and drains the queue against the DUT mid-cycle.
module tb_pc_target_btb;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] ALU_OP = 7'b0110011;
`ifdef PCT_MISALIGN_CHK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    typedef enum {S_PCF, S_PCPLUS4, S_PRED_TAKEN, S_PRED_TARGET,
                  S_REDIRECT, S_REDIRECT_PC, S_CNT, S_MISALIGN} sig_e;
    typedef struct {
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_vec;
    int   n_bad;

    pc_target_btb_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();

    pc_target_btb #(
        .DATA_WIDTH (32),
        .BTB_ENTRIES(16),
        .RESET_PC   (32'h0),
        .CNT_WIDTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] probe(input sig_e s);
        case (s)
            S_PCF:         return bus.PCF;
            S_PCPLUS4:     return bus.PCPlus4F;
            S_PRED_TAKEN:  return {31'b0, bus.pred_taken_f};
            S_PRED_TARGET: return bus.pred_target_f;
            S_REDIRECT:    return {31'b0, bus.redirect};
            S_REDIRECT_PC: return bus.redirect_pc;
            S_CNT:         return {28'b0, bus.mispredict_cnt};
            default:       return {31'b0, bus.misalign};
        endcase
    endfunction

    function automatic void expect_val(input sig_e s, input logic [31:0] v);
        exp_q.push_back('{s, v});
    endfunction

    task automatic drive_ex(input logic v, input logic [6:0] op, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] alu, input logic bt,
                            input logic pt, input logic [31:0] ptgt);
        bus.ex_valid        = v;
        bus.ex_op           = op;
        bus.ex_pc           = pc;
        bus.ex_imm          = imm;
        bus.ex_alu_result   = alu;
        bus.ex_branch_taken = bt;
        bus.ex_pred_taken   = pt;
        bus.ex_pred_target  = ptgt;
    endtask

    task automatic ex_idle();
        drive_ex(1'b0, 7'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        rst = 1'b1;
        bus.stall_f = 1'b0;
        ex_idle();
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            ex_idle();
            case (c)
                0: begin
                    drive_ex(1'b1, JAL, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
                    expect_val(S_REDIRECT, 32'd0);
                    expect_val(S_PCF, 32'h0);
                    expect_val(S_CNT, 32'd0);
                end
                1: expect_val(S_REDIRECT, 32'd0);
                2: begin
                    rst = 1'b0;
                    expect_val(S_PCF, 32'h0);
                    expect_val(S_PRED_TAKEN, 32'd0);
                    expect_val(S_CNT, 32'd0);
                    expect_val(S_PCPLUS4, 32'h4);
                    expect_val(S_REDIRECT, 32'd0);
                end
                3: begin
                    expect_val(S_PCF, 32'h4);
                    expect_val(S_PRED_TAKEN, 32'd0);
                end
                default: begin
                    expect_val(S_PCF, 32'h8);
                    expect_val(S_PRED_TAKEN, 32'd0);
                    expect_val(S_PRED_TARGET, 32'hC);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL reset c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal();
        exp_t e;
        logic [31:0] obs;
        for (int c = 0; c < 4; c++) begin
            ex_idle();
            case (c)
                0: begin
                    drive_ex(1'b1, JAL, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h30);
                    expect_val(S_MISALIGN, 32'd0);
                    expect_val(S_CNT, 32'd0);
                end
                1: begin
                    drive_ex(1'b1, JAL, 32'h0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
                    expect_val(S_PCF, 32'h30);
                    expect_val(S_CNT, 32'd1);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h10);
                end
                2: begin
                    expect_val(S_PCF, 32'h10);
                    expect_val(S_CNT, 32'd2);
                    expect_val(S_PRED_TAKEN, 32'd1);
                    expect_val(S_PRED_TARGET, 32'h30);
                    expect_val(S_REDIRECT, 32'd0);
                end
                default: begin
                    expect_val(S_PCF, 32'h30);
                    expect_val(S_PRED_TAKEN, 32'd0);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL jal c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jalr();
        exp_t e;
        logic [31:0] obs;
        for (int c = 0; c < 3; c++) begin
            ex_idle();
            case (c)
                0: begin
                    drive_ex(1'b1, JALR, 32'h50, 32'h7, 32'h105, 1'b0, 1'b1, 32'h104);
                    expect_val(S_REDIRECT, 32'd0);
                    expect_val(S_REDIRECT_PC, 32'h104);
                end
                1: begin
                    drive_ex(1'b1, JALR, 32'h50, 32'h7, 32'h105, 1'b0, 1'b1, 32'h200);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h104);
                    expect_val(S_CNT, 32'd2);
                    expect_val(S_PCF, 32'h38);
                end
                default: begin
                    expect_val(S_PCF, 32'h104);
                    expect_val(S_CNT, 32'd3);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL jalr c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [31:0] obs;
        for (int c = 0; c < 5; c++) begin
            ex_idle();
            case (c)
                0: begin
                    drive_ex(1'b1, BRANCH, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b1, 32'h4);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h0);
                    expect_val(S_CNT, 32'd3);
                end
                1: begin
                    drive_ex(1'b1, BRANCH, 32'h40, 32'h40, 32'h0, 1'b0, 1'b1, 32'h80);
                    expect_val(S_PCF, 32'h0);
                    expect_val(S_PRED_TAKEN, 32'd1);
                    expect_val(S_PRED_TARGET, 32'h10);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h44);
                    expect_val(S_CNT, 32'd4);
                end
                2: begin
                    drive_ex(1'b1, BRANCH, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b0, 1'b1, 32'h4);
                    expect_val(S_PCF, 32'h44);
                    expect_val(S_REDIRECT_PC, 32'h0);
                    expect_val(S_CNT, 32'd5);
                end
                3: begin
                    expect_val(S_PCF, 32'h0);
                    expect_val(S_PRED_TAKEN, 32'd0);
                    expect_val(S_PRED_TARGET, 32'h4);
                end
                default: begin
                    drive_ex(1'b1, BRANCH, 32'h300, 32'hFFFF_FF00, 32'h0, 1'b1, 1'b1, 32'h200);
                    expect_val(S_REDIRECT, 32'd0);
                    expect_val(S_REDIRECT_PC, 32'h200);
                    expect_val(S_CNT, 32'd6);
                    expect_val(S_PCF, 32'h4);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL branch c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] obs;
        for (int c = 0; c < 6; c++) begin
            ex_idle();
            bus.stall_f = (c < 4);
            case (c)
                0: begin
                    drive_ex(1'b1, BRANCH, 32'h200, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h300);
                    expect_val(S_PCF, 32'h8);
                    expect_val(S_CNT, 32'd6);
                end
                1: begin
                    expect_val(S_PCF, 32'h300);
                    expect_val(S_CNT, 32'd7);
                end
                5: expect_val(S_PCF, 32'h304);
                default: expect_val(S_PCF, 32'h300);
            endcase
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL stall c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
        bus.stall_f = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] obs;
        logic [31:0] exp_cnt;
        exp_cnt = 32'd7;
        for (int c = 0; c < 12; c++) begin
            ex_idle();
            if (c < 11) begin
                drive_ex(1'b1, ALU_OP, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2000);
                expect_val(S_REDIRECT, 32'd1);
                expect_val(S_REDIRECT_PC, 32'h1004);
            end else begin
                expect_val(S_REDIRECT, 32'd0);
                expect_val(S_PCF, 32'h1004);
            end
            expect_val(S_CNT, exp_cnt);
            exp_cnt = (exp_cnt == 32'd15) ? 32'd15 : exp_cnt + 32'd1;
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL b2b c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        logic [31:0] obs;
        for (int c = 0; c < 3; c++) begin
            ex_idle();
            case (c)
                0: begin
                    drive_ex(1'b1, JAL, 32'h80, 32'h82, 32'h0, 1'b0, 1'b0, 32'h0);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h102);
                    expect_val(S_MISALIGN, {31'b0, MIS_EN});
                end
                1: begin
                    drive_ex(1'b1, ALU_OP, 32'h7C, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
                    expect_val(S_PCF, 32'h102);
                    expect_val(S_REDIRECT, 32'd1);
                    expect_val(S_REDIRECT_PC, 32'h80);
                    expect_val(S_MISALIGN, 32'd0);
                end
                default: begin
                    expect_val(S_PCF, 32'h80);
                    expect_val(S_PRED_TAKEN, MIS_EN ? 32'd0 : 32'd1);
                    expect_val(S_PRED_TARGET, MIS_EN ? 32'h84 : 32'h102);
                    expect_val(S_CNT, 32'd15);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs = probe(e.sig);
                n_vec++;
                if (obs !== e.val) begin
                    n_bad++;
                    $display("FAIL misalign c%0d %s: got %h expected %h", c, e.sig.name(), obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_jal();
        test_jalr();
        test_branch();
        test_stall();
        test_back_to_back();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
